// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter with a registered 4:1 data path.
// Optional grant-length limit enabled by defining ARBITRO_TIMEOUT_EN (limit set by MAX_CICLOS).
module arbitro_rr4 #(
    parameter int unsigned MAX_CICLOS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] dado0,
    input  logic [3:0] dado1,
    input  logic [3:0] dado2,
    input  logic [3:0] dado3,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [3:0] saida,
    output logic       valido,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CONCEDIDO = 2'd1,
        PAUSA     = 2'd2
    } estado_t;

    estado_t    estado;
    logic [1:0] ultimo;
    logic [1:0] vencedor_c;
    logic [3:0] dado_sel_c;
    logic       fim_c;
    logic       manter_c;

    if (MAX_CICLOS < 2 || MAX_CICLOS > 255) begin : g_max_ciclos_invalido
        $error("arbitro_rr4: MAX_CICLOS must be in 2..255");
    end

    // Round-robin pick: the lowest offset after ultimo wins, so scan offsets downward.
    always_comb begin
        logic [1:0] idx;
        vencedor_c = ultimo;
        idx        = ultimo;
        for (int k = 4; k >= 1; k--) begin
            idx = ultimo + 2'(k);
            if (req[idx]) begin
                vencedor_c = idx;
            end
        end
    end

    always_comb begin
        dado_sel_c = dado0;
        case (sel)
            2'd0:    dado_sel_c = dado0;
            2'd1:    dado_sel_c = dado1;
            2'd2:    dado_sel_c = dado2;
            default: dado_sel_c = dado3;
        endcase
    end

`ifdef ARBITRO_TIMEOUT_EN
    localparam int unsigned CW = 8;
    logic [CW-1:0] ciclos;

    assign fim_c = (ciclos == CW'(MAX_CICLOS));
`else
    assign fim_c = 1'b0;
`endif

    assign manter_c = req[sel] && !fim_c;

    // Arbiter FSM; every output is updated here so all of them come straight from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            gnt     <= 4'b0000;
            sel     <= 2'b00;
            saida   <= 4'b0000;
            valido  <= 1'b0;
            ocupado <= 1'b0;
            ultimo  <= 2'd3;
`ifdef ARBITRO_TIMEOUT_EN
            ciclos  <= '0;
`endif
        end else begin
            case (estado)
                OCIOSO: begin
                    valido <= 1'b0;
                    if (|req) begin
                        estado  <= CONCEDIDO;
                        gnt     <= 4'(1) << vencedor_c;
                        sel     <= vencedor_c;
                        ultimo  <= vencedor_c;
                        ocupado <= 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
                        ciclos  <= '0;
`endif
                    end else begin
                        gnt     <= 4'b0000;
                        ocupado <= 1'b0;
                    end
                end
                CONCEDIDO: begin
                    if (manter_c) begin
                        saida  <= dado_sel_c;
                        valido <= 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
                        ciclos <= ciclos + CW'(1);
`endif
                    end else begin
                        // Release (or forced release): one dead cycle before re-arbitration.
                        estado <= PAUSA;
                        gnt    <= 4'b0000;
                        valido <= 1'b0;
                    end
                end
                PAUSA: begin
                    estado  <= OCIOSO;
                    gnt     <= 4'b0000;
                    valido  <= 1'b0;
                    ocupado <= 1'b0;
                end
                default: begin
                    estado  <= OCIOSO;
                    gnt     <= 4'b0000;
                    valido  <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/arbitro_rr4.md
ARBITRO_RR4 -- requirements
Module: arbitro_rr4

Interface
REQ-001 The block SHALL have parameter MAX_CICLOS, default 8, giving the maximum grant length in cycles; it is used only when ARBITRO_TIMEOUT_EN is defined, and its legal range is 2..255.
REQ-002 Port clock  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  reset, synchronous, active-high.
REQ-004 Port req  input  4  request lines; bit i is requester i, held high for the whole transaction.
REQ-005 Port dado0, dado1, dado2, dado3  input  4 each  data from requesters 0..3.
REQ-006 Port gnt  output  4  one-hot grant, or 4'b0000 when nothing is granted.
REQ-007 Port sel  output  2  index of the current or last granted requester, driving the downstream 4:1 data mux select.
REQ-008 Port saida  output  4  registered data of the granted requester.
REQ-009 Port valido  output  1  saida carries a new sample this cycle.
REQ-010 Port ocupado  output  1  high whenever the FSM is not in OCIOSO.

Function
REQ-011 The FSM SHALL have exactly three states, OCIOSO, CONCEDIDO and PAUSA; all state, gnt, sel, saida and valido SHALL be registered.
REQ-012 OCIOSO, req==0: the FSM SHALL stay in OCIOSO with gnt=0.
REQ-013 OCIOSO, req!=0: the winner is the first set req bit scanning from index (ultimo+1) mod 4 upward with wrap; on the next edge the FSM SHALL go to CONCEDIDO, set gnt=1<<winner, sel=winner and ultimo=winner (latency 1 cycle from req to gnt).
REQ-014 CONCEDIDO, req[sel]=1: each edge SHALL load saida from dado[sel] and set valido=1; gnt SHALL be held unchanged.
REQ-015 CONCEDIDO, req[sel]=0: on that edge the FSM SHALL go to PAUSA, clear gnt and clear valido; saida SHALL hold its last value.
REQ-016 PAUSA: the FSM SHALL return to OCIOSO on the next edge unconditionally, giving one dead cycle; a new grant SHALL appear no earlier than 2 cycles after release.
REQ-017 Other requesters' req changes during CONCEDIDO or PAUSA SHALL NOT affect gnt, sel or saida.
REQ-018 valido SHALL be 0 in OCIOSO and PAUSA; sel SHALL keep its last value outside CONCEDIDO.
REQ-019 A single requester re-requesting with no competition SHALL be granted again after the PAUSA cycle; fairness applies only among simultaneous requests.
REQ-020 Illegal state encodings SHALL go to OCIOSO with gnt=0 on the next edge.

Reset
REQ-021 When reset=1 at an edge: state=OCIOSO, gnt=4'b0000, sel=2'b00, saida=4'b0000, valido=0, ultimo=3 (requester 0 has first priority), timeout counter=0.
REQ-022 Reset SHALL take priority over every transition, including mid-grant; the grant SHALL be dropped on that edge without passing through PAUSA.

Configuration
REQ-023 With macro ARBITRO_TIMEOUT_EN defined, a counter SHALL clear on entry to CONCEDIDO and increment each CONCEDIDO cycle.
REQ-024 With ARBITRO_TIMEOUT_EN defined, the FSM SHALL force CONCEDIDO to PAUSA after MAX_CICLOS valid cycles even if req[sel] is still 1, so the next arbitration rotates past the current holder.
REQ-025 Without ARBITRO_TIMEOUT_EN, no counter SHALL exist and a grant SHALL last until req[sel] falls.

Verification
REQ-026 Reset, then req=4'b1111 -> gnt=4'b0001 and sel=0 one cycle later; drop req[0] -> gnt=0 for 2 cycles, then gnt=4'b0010.
REQ-027 Hold req=4'b1111, dropping each holder after 3 valid cycles -> grant order 0,1,2,3,0 with valido high exactly 3 cycles per grant.
REQ-028 dado2=4'hA, grant requester 2, change dado2 to 4'h5 mid-grant -> saida=4'hA then 4'h5, each one cycle after dado2 changes; saida stays 4'h5 after release.
REQ-029 Assert reset during CONCEDIDO for requester 1 -> gnt=0, valido=0, saida=0 on that edge; with req=4'b0011 afterwards, requester 0 is granted first.
REQ-030 ARBITRO_TIMEOUT_EN defined, MAX_CICLOS=4, req=4'b0101 held -> requester 0 granted for exactly 4 valid cycles, 1 dead cycle, then requester 2; without the macro, requester 0 keeps the grant indefinitely.
